// File: rtl/mem_req_adapter.sv
// LSU valid/ready to req/gnt/rvalid memory port adapter with in-order tag FIFO.
// Optional watchdog enabled by defining MEM_REQ_ADAPTER_TIMEOUT_EN.
module mem_req_adapter #(
  parameter int ADDR_W          = 64,
  parameter int TAG_W           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [3:0]        req_be_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic [ADDR_W-1:0] address_o,
  output logic [31:0]       data_wdata_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_we_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic [CW-1:0]     outstanding_o,
  output logic              spurious_o
`ifdef MEM_REQ_ADAPTER_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {IDLE, PEND} state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             we;
  } ent_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  ent_t              fifo_q [MAX_OUTSTANDING];
  logic              fire, pop, blk;

`ifdef MEM_REQ_ADAPTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_q, to_d;

  always_comb begin
    tmr_d = tmr_q;
    if (pop || cnt_q == '0)
      tmr_d = '0;
    else if (tmr_q != TW'(TIMEOUT_CYCLES))
      tmr_d = tmr_q + TW'(1);
    to_d = to_q | (tmr_d == TW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      to_q  <= to_d;
    end
  end

  assign blk       = to_q;
  assign timeout_o = to_q;
`else
  assign blk = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    data_req_o = (state_q == PEND) && !blk
               && (cnt_q < CW'(MAX_OUTSTANDING));
    fire        = data_req_o && data_gnt_i;
    req_ready_o = (state_q == IDLE) || fire;
    pop         = data_rvalid_i && (cnt_q != '0);
    if (req_valid_i && req_ready_o) begin
      state_d = PEND;
      addr_d  = req_addr_i;
      we_d    = req_we_i;
      be_d    = req_be_i;
      wdata_d = req_wdata_i;
      tag_d   = req_tag_i;
    end else if (fire) begin
      state_d = IDLE;
    end
    // Pointers wrap explicitly so MAX_OUTSTANDING=1 also works.
    if (fire)
      wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PW'(1);
    if (pop)
      rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(fire) - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fire) fifo_q[wptr_q] <= '{tag: tag_q, we: we_q};
  end

  assign address_o     = addr_q;
  assign data_wdata_o  = wdata_q;
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign resp_valid_o  = pop;
  assign resp_rdata_o  = data_rdata_i;
  assign resp_tag_o    = fifo_q[rptr_q].tag;
  assign resp_we_o     = fifo_q[rptr_q].we;
  assign outstanding_o = cnt_q;
  assign spurious_o    = data_rvalid_i && (cnt_q == '0);

endmodule

// File: tb/tb_mem_req_adapter.sv
// Scoreboard bench for mem_req_adapter: grant and response monitors
// pop expectations pushed by the directed stimulus.
module tb_mem_req_adapter;

  localparam int ADDR_W = 64;
  localparam int TAG_W  = 4;
  localparam int MAXO   = 4;
  localparam int CW     = $clog2(MAXO + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             we;
    logic [31:0]      rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic req_we = 1'b0;
  logic [3:0] req_be = '0;
  logic [31:0] req_wdata = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [ADDR_W-1:0] address;
  logic [31:0] wdata_o;
  logic dreq, dwe;
  logic [3:0] dbe;
  logic gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic resp_valid, resp_we;
  logic [31:0] resp_rdata;
  logic [TAG_W-1:0] resp_tag;
  logic [CW-1:0] outst;
  logic spurious;
`ifdef MEM_REQ_ADAPTER_TIMEOUT_EN
  logic timeout;
`endif

  int checks = 0;
  int errors = 0;
  req_t req_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  mem_req_adapter #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_be_i(req_be),
    .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .address_o(address), .data_wdata_o(wdata_o), .data_req_o(dreq),
    .data_we_o(dwe), .data_be_o(dbe), .data_gnt_i(gnt),
    .data_rvalid_i(rvalid), .data_rdata_i(rdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_we_o(resp_we), .resp_tag_o(resp_tag),
    .outstanding_o(outst), .spurious_o(spurious)
`ifdef MEM_REQ_ADAPTER_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                       input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic [TAG_W-1:0] t,
                       input logic push);
    req_valid = v; req_addr = a; req_we = w;
    req_be = b; req_wdata = d; req_tag = t;
    if (push) req_q.push_back('{addr: a, we: w, be: b, wdata: d, tag: t});
  endtask

  task automatic rsp(input logic [TAG_W-1:0] t, input logic w,
                     input logic [31:0] d);
    rvalid = 1'b1;
    rdata = d;
    rsp_q.push_back('{tag: t, we: w, rdata: d});
  endtask

  // Memory-side grant monitor
  always @(negedge clk) begin
    if (rst_n && dreq && gnt) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected addr %0h", address);
      end else begin
        req_t e;
        e = req_q.pop_front();
        chk("gnt_addr", address, e.addr);
        chk("gnt_we", {63'd0, dwe}, {63'd0, e.we});
        chk("gnt_be", {60'd0, dbe}, {60'd0, e.be});
        chk("gnt_wdata", {32'd0, wdata_o}, {32'd0, e.wdata});
      end
    end
  end

  // LSU-side response monitor
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected tag %0h", resp_tag);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("resp_tag", {60'd0, resp_tag}, {60'd0, e.tag});
        chk("resp_we", {63'd0, resp_we}, {63'd0, e.we});
        chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
      end
    end
  end

  initial begin
    // Reset
    step(); step();
    rst_n = 1'b1;
    settle();
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_dreq", {63'd0, dreq}, 64'd0);
    chk("rst_addr", address, 64'd0);
    chk("rst_wdata", {32'd0, wdata_o}, 64'd0);
    chk("rst_we_be", {59'd0, dwe, dbe}, 64'd0);
    chk("rst_outst", {61'd0, outst}, 64'd0);
    chk("rst_spur", {63'd0, spurious}, 64'd0);

    // Single read
    step();
    drive(1, 64'h1000, 0, 4'hF, 0, 4'd3, 1);
    settle();
    chk("t1_ready", {63'd0, req_ready}, 64'd1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("t1_dreq", {63'd0, dreq}, 64'd1);
    step();
    gnt = 1'b1;
    settle();
    chk("t1_ready_gnt", {63'd0, req_ready}, 64'd1);
    step();
    gnt = 1'b0;
    settle();
    chk("t1_outst1", {61'd0, outst}, 64'd1);
    chk("t1_dreq_lo", {63'd0, dreq}, 64'd0);
    step();
    step();
    rsp(4'd3, 0, 32'hDEADBEEF);
    settle();
    chk("t1_rvalid", {63'd0, resp_valid}, 64'd1);
    step();
    rvalid = 1'b0;
    settle();
    chk("t1_outst0", {61'd0, outst}, 64'd0);
    chk("t1_rv_lo", {63'd0, resp_valid}, 64'd0);

    // Back-to-back reads, tags 0..3
    step();
    drive(1, 64'h2000, 0, 4'hF, 0, 4'd0, 1);
    step();
    for (int i = 1; i < 4; i++) begin
      drive(1, 64'h2000 + 64'(4 * i), 0, 4'hF, 0, 4'(i), 1);
      gnt = 1'b1;
      settle();
      chk("b2b_dreq", {63'd0, dreq}, 64'd1);
      chk("b2b_ready", {63'd0, req_ready}, 64'd1);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("b2b_dreq_last", {63'd0, dreq}, 64'd1);
    step();

    // Full stall with tag 4
    gnt = 1'b0;
    drive(1, 64'h3000, 0, 4'hF, 0, 4'd4, 1);
    settle();
    chk("full_outst4", {61'd0, outst}, 64'd4);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("full_dreq_lo", {63'd0, dreq}, 64'd0);
    chk("full_addr_held", address, 64'h3000);
    chk("full_ready_lo", {63'd0, req_ready}, 64'd0);
    step();
    gnt = 1'b1;
    settle();
    chk("full_gnt_ign", {63'd0, dreq}, 64'd0);
    chk("full_gnt_ready", {63'd0, req_ready}, 64'd0);
    step();
    gnt = 1'b0;
    rsp(4'd0, 0, 32'h100);
    settle();
    chk("full_dreq_rv", {63'd0, dreq}, 64'd0);
    step();
    rvalid = 1'b0;
    settle();
    chk("full_dreq_up", {63'd0, dreq}, 64'd1);
    chk("full_outst3", {61'd0, outst}, 64'd3);
    step();
    gnt = 1'b1;
    settle();
    chk("full_ready_gnt", {63'd0, req_ready}, 64'd1);
    step();
    gnt = 1'b0;
    rsp(4'd1, 0, 32'h101);
    settle();
    chk("drain_outst4", {61'd0, outst}, 64'd4);
    step();
    rsp(4'd2, 0, 32'h102);
    settle();
    chk("drain_outst3", {61'd0, outst}, 64'd3);
    step();
    rvalid = 1'b0;
    drive(1, 64'h3004, 1, 4'h3, 32'hCAFEF00D, 4'd5, 1);
    settle();
    chk("sim_outst2", {61'd0, outst}, 64'd2);

    // Simultaneous grant and rvalid at count 2
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    gnt = 1'b1;
    rsp(4'd3, 0, 32'h103);
    settle();
    chk("sim_dreq", {63'd0, dreq}, 64'd1);
    chk("sim_tag_old", {60'd0, resp_tag}, 64'd3);
    step();
    gnt = 1'b0;
    rvalid = 1'b0;
    settle();
    chk("sim_outst_kept", {61'd0, outst}, 64'd2);
    step();
    rsp(4'd4, 0, 32'h104);
    step();
    rsp(4'd5, 1, 32'h105);
    step();
    rvalid = 1'b0;
    settle();
    chk("sim_outst0", {61'd0, outst}, 64'd0);

    // Grant delay on a write
    step();
    drive(1, 64'h4000, 1, 4'hC, 32'h12345678, 4'd6, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("gd_addr", address, 64'h4000);
      chk("gd_wdata", {32'd0, wdata_o}, 64'h12345678);
      chk("gd_we_be", {59'd0, dwe, dbe}, 64'h1C);
      chk("gd_ready", {63'd0, req_ready}, 64'd0);
      chk("gd_dreq", {63'd0, dreq}, 64'd1);
      step();
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    step();
    rsp(4'd6, 1, 32'h0);
    step();
    rvalid = 1'b0;

    // Spurious rvalid at count 0
    step();
    rvalid = 1'b1;
    rdata = 32'h55;
    settle();
    chk("spur_hi", {63'd0, spurious}, 64'd1);
    chk("spur_norv", {63'd0, resp_valid}, 64'd0);
    step();
    rvalid = 1'b0;
    settle();
    chk("spur_lo", {63'd0, spurious}, 64'd0);

    // Reset with two outstanding
    step();
    drive(1, 64'h5000, 0, 4'hF, 0, 4'd7, 1);
    step();
    drive(1, 64'h5004, 0, 4'hF, 0, 4'd8, 1);
    gnt = 1'b1;
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    gnt = 1'b0;
    settle();
    chk("rr_outst2", {61'd0, outst}, 64'd2);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    chk("rr_outst0", {61'd0, outst}, 64'd0);
    chk("rr_dreq", {63'd0, dreq}, 64'd0);
    step();
    rvalid = 1'b1;
    settle();
    chk("rr_spur", {63'd0, spurious}, 64'd1);
    chk("rr_norv", {63'd0, resp_valid}, 64'd0);
    step();
    rvalid = 1'b0;

`ifdef MEM_REQ_ADAPTER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      drive(1, 64'h6000, 0, 4'hF, 0, 4'd9, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      settle();
      while (!timeout && n < 40) begin
        step();
        settle();
        n++;
      end
      chk("to_cycles", 64'(n), 64'd16);
      step();
      drive(1, 64'h6004, 0, 4'hF, 0, 4'd10, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      gnt = 1'b1;
      settle();
      chk("to_dreq_lo", {63'd0, dreq}, 64'd0);
      chk("to_sticky", {63'd0, timeout}, 64'd1);
      step();
      gnt = 1'b0;
    end
`endif

    step();
    step();
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
